fu_control_multibranch: RTL and testbench

Parametrised valid/ready control for a CGRA functional unit; the next generation of the superpolyvalent FU control. Generalises fork width, branch count and delay-counter width. Adds a multi-token initial preload, a runtime clear and a sticky illegal-select flag. Sits beside the FU datapath inside each processing element and drives the FU output register enables and consumer valids.

---
 rtl/fu_control_multibranch.sv | 153 +++++++++++++++
 tb/tb_fu_control_multibranch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fu_control_multibranch.sv
// Valid/ready control for a CGRA functional unit: multi-consumer fork,
// branch-valid demux, initial token preload, periodic delayed valid and a
// sticky illegal-select flag.
module fu_control_multibranch #(
  parameter int NUM_READYS   = 6,
  parameter int NUM_BRANCHES = 2,
  parameter int SEL_W        = 1,
  parameter int DELAY_W      = 16,
  parameter int INIT_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_v,
  output logic                    in_r,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_READYS-1:0]   dout_r,
  input  logic [NUM_READYS-1:0]   fork_mask,
  input  logic [INIT_W-1:0]       initial_valid_count,
  input  logic [DELAY_W-1:0]      delay_value,
  output logic                    out_v,
  output logic                    out_d_v,
  output logic [NUM_BRANCHES-1:0] out_b_v,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                  r_state, w_state_next;
  logic                    r_v, w_v_next;
  logic [NUM_BRANCHES-1:0] r_b, w_b_next;
  logic [INIT_W-1:0]       r_init_cnt, w_init_cnt_next;
  logic [DELAY_W-1:0]      r_delay_cnt, w_delay_cnt_next;
  logic                    r_sel_err, w_sel_err_next;

  logic [NUM_READYS-1:0]   w_ready_term;
  logic                    w_ready_all;
  logic [NUM_BRANCHES-1:0] w_sel_hit;
  logic                    w_sel_illegal;
  logic                    w_delay_bypass;
  logic                    w_delay_hit;

  // A consumer outside the fork never blocks; an empty mask means always ready.
  generate
    for (genvar gi = 0; gi < NUM_READYS; gi++) begin : g_ready
      assign w_ready_term[gi] = dout_r[gi] | ~fork_mask[gi];
    end
  endgenerate
  assign w_ready_all = &w_ready_term;

  // One-hot branch decode; a select matching no branch is illegal.
  generate
    for (genvar gi = 0; gi < NUM_BRANCHES; gi++) begin : g_sel
      assign w_sel_hit[gi] = (sel == SEL_W'(gi));
    end
  endgenerate
  assign w_sel_illegal = ~|w_sel_hit;

  assign in_r    = w_ready_all & (r_state == S_RUN);
  assign out_v   = r_v & w_ready_all;
  assign out_b_v = r_b & {NUM_BRANCHES{w_ready_all}};
  assign sel_err = r_sel_err;

  // Periods 0 and 1 both mean "every transfer"; otherwise fire on the last
  // count of the period. Compared in DELAY_W bits so the all-ones period works.
  assign w_delay_bypass = (delay_value <= DELAY_W'(1));
  assign w_delay_hit    = (r_delay_cnt == delay_value - DELAY_W'(1));
  assign out_d_v        = out_v & (w_delay_bypass | w_delay_hit);

  // Next-state logic: preload sequencing, token capture and delay counting.
  always_comb begin
    w_state_next     = r_state;
    w_v_next         = r_v;
    w_b_next         = r_b;
    w_init_cnt_next  = r_init_cnt;
    w_delay_cnt_next = r_delay_cnt;
    w_sel_err_next   = r_sel_err;

    // Every output transfer, preload tokens included, advances the period.
    if (out_v) begin
      if (w_delay_bypass || w_delay_hit) begin
        w_delay_cnt_next = '0;
      end else begin
        w_delay_cnt_next = r_delay_cnt + DELAY_W'(1);
      end
    end

    case (r_state)
      S_LOAD: begin
        w_init_cnt_next = initial_valid_count;
        w_v_next        = |initial_valid_count;
        w_b_next        = '0;
        w_state_next    = (|initial_valid_count) ? S_INIT : S_RUN;
      end
      S_INIT: begin
        w_b_next = '0;
        if (out_v) begin
          // Last preload token leaves a one-cycle bubble before RUN accepts.
          if (r_init_cnt == INIT_W'(1)) begin
            w_init_cnt_next = '0;
            w_v_next        = 1'b0;
            w_state_next    = S_RUN;
          end else begin
            w_init_cnt_next = r_init_cnt - INIT_W'(1);
          end
        end
      end
      S_RUN: begin
        if (in_r) begin
          w_v_next = in_v;
          w_b_next = w_sel_hit & {NUM_BRANCHES{in_v}};
          if (in_v && w_sel_illegal) begin
            w_sel_err_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_LOAD;
      end
    endcase
  end

  // State registers; clear restarts exactly like reset but synchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_v         <= 1'b0;
      r_b         <= '0;
      r_init_cnt  <= '0;
      r_delay_cnt <= '0;
      r_sel_err   <= 1'b0;
    end else if (clear) begin
      r_state     <= S_LOAD;
      r_v         <= 1'b0;
      r_b         <= '0;
      r_init_cnt  <= '0;
      r_delay_cnt <= '0;
      r_sel_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_v         <= w_v_next;
      r_b         <= w_b_next;
      r_init_cnt  <= w_init_cnt_next;
      r_delay_cnt <= w_delay_cnt_next;
      r_sel_err   <= w_sel_err_next;
    end
  end

endmodule

// File: tb/tb_fu_control_multibranch.sv
// Directed bench for fu_control_multibranch: preload, fork gating, delay
// period, branch demux, clear and asynchronous reset.
module tb_fu_control_multibranch;

  localparam int NR = 6;
  localparam int NB = 3;
  localparam int SW = 2;
  localparam int DW = 4;
  localparam int IW = 4;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          in_v;
  logic          in_r;
  logic [SW-1:0] sel;
  logic [NR-1:0] dout_r;
  logic [NR-1:0] fork_mask;
  logic [IW-1:0] ivc;
  logic [DW-1:0] dval;
  logic          out_v;
  logic          out_d_v;
  logic [NB-1:0] out_b_v;
  logic          sel_err;

  int n_vec;
  int n_err;

  logic [2:0] b_exp [4];

  fu_control_multibranch #(
    .NUM_READYS  (NR),
    .NUM_BRANCHES(NB),
    .SEL_W       (SW),
    .DELAY_W     (DW),
    .INIT_W      (IW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .clear              (clear),
    .in_v               (in_v),
    .in_r               (in_r),
    .sel                (sel),
    .dout_r             (dout_r),
    .fork_mask          (fork_mask),
    .initial_valid_count(ivc),
    .delay_value        (dval),
    .out_v              (out_v),
    .out_d_v            (out_d_v),
    .out_b_v            (out_b_v),
    .sel_err            (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts, prints one line, flags a miscompare.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    $display("vec %0d %s obs=%0h exp=%0h", n_vec, tag, obs, exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    b_exp = '{3'b001, 3'b010, 3'b100, 3'b000};
    rst = 1'b1; clear = 1'b0; in_v = 1'b0; sel = '0;
    dout_r = '1; fork_mask = '1; ivc = 4'd3; dval = '0;

    // Outputs while reset is held
    #1;
    chk("rst_out_v",   32'(out_v),   0);
    chk("rst_in_r",    32'(in_r),    0);
    chk("rst_out_b_v", 32'(out_b_v), 0);
    chk("rst_out_d_v", 32'(out_d_v), 0);
    chk("rst_sel_err", 32'(sel_err), 0);

    // Three preload tokens, bubble, then upstream flows with 1-cycle latency
    @(negedge clk); rst = 1'b0; in_v = 1'b1; #1;
    chk("t1_load_in_r",  32'(in_r),  0);
    chk("t1_load_out_v", 32'(out_v), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t1_init_out_v",   32'(out_v),   1);
      chk("t1_init_in_r",    32'(in_r),    0);
      chk("t1_init_out_d_v", 32'(out_d_v), 1);
    end
    @(negedge clk); #1;
    chk("t1_bubble_out_v", 32'(out_v), 0);
    chk("t1_bubble_in_r",  32'(in_r),  1);
    @(negedge clk); in_v = 1'b0; #1;
    chk("t1_first_out_v", 32'(out_v),   1);
    chk("t1_first_b",     32'(out_b_v), 3'b001);
    chk("t1_first_in_r",  32'(in_r),    1);
    @(negedge clk); #1;
    chk("t1_follow_out_v", 32'(out_v), 0);

    // Period 4 over 10 back-to-back tokens
    dval = 4'd4; in_v = 1'b1; sel = 2'd1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) in_v = 1'b0;
      #1;
      chk("t3_out_v",   32'(out_v),   1);
      chk("t3_out_d_v", 32'(out_d_v), 32'(k % 4 == 0));
      chk("t3_b",       32'(out_b_v), 3'b010);
    end

    // Branch demux with period 0; sel 3 is illegal and sets the sticky flag
    @(negedge clk); dval = '0; in_v = 1'b1; sel = 2'd0; #1;
    chk("t4_idle_out_v", 32'(out_v), 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j < 3) sel = SW'(j + 1);
      else in_v = 1'b0;
      #1;
      chk("t4_out_v",    32'(out_v),   1);
      chk("t4_out_d_v",  32'(out_d_v), 1);
      chk("t4_b",        32'(out_b_v), 32'(b_exp[j]));
      chk("t4_sel_err",  32'(sel_err), 32'(j == 3));
    end

    // Fork gated only by consumers 0 and 1
    @(negedge clk); fork_mask = 6'b000011; dout_r = 6'b111110; in_v = 1'b1; sel = 2'd2; #1;
    chk("t2_sticky_err", 32'(sel_err), 1);
    chk("t2_block_in_r", 32'(in_r),    0);
    chk("t2_block_out_v",32'(out_v),   0);
    @(negedge clk); dout_r = 6'b010111; #1;
    chk("t2_open_in_r",  32'(in_r),  1);
    chk("t2_open_out_v", 32'(out_v), 0);
    @(negedge clk); dout_r = 6'b101110; in_v = 1'b0; #1;
    chk("t2_stall_in_r",  32'(in_r),    0);
    chk("t2_stall_out_v", 32'(out_v),   0);
    chk("t2_stall_b",     32'(out_b_v), 0);
    @(negedge clk); dout_r = 6'b111100; #1;
    chk("t2_stall2_out_v", 32'(out_v), 0);
    @(negedge clk); dout_r = 6'b000011; #1;
    chk("t2_drain_out_v", 32'(out_v),   1);
    chk("t2_drain_b",     32'(out_b_v), 3'b100);
    chk("t2_drain_in_r",  32'(in_r),    1);
    @(negedge clk); dout_r = '1; #1;
    chk("t2_nodup_out_v", 32'(out_v), 0);
    @(negedge clk); fork_mask = '0; dout_r = '0; #1;
    chk("t2_nomask_in_r", 32'(in_r), 1);

    // Clear mid-stream with a two-token preload; preload counts toward period 3
    @(negedge clk); fork_mask = '1; dout_r = '1; dval = 4'd3; in_v = 1'b1; sel = 2'd0; #1;
    @(negedge clk); #1;
    chk("t5_pre_out_v",   32'(out_v),   1);
    chk("t5_pre_out_d_v", 32'(out_d_v), 0);
    @(negedge clk); clear = 1'b1; ivc = 4'd2; #1;
    chk("t5_clr_out_v",   32'(out_v),   1);
    chk("t5_clr_out_d_v", 32'(out_d_v), 0);
    @(negedge clk); clear = 1'b0; #1;
    chk("t5_load_out_v",   32'(out_v),   0);
    chk("t5_load_in_r",    32'(in_r),    0);
    chk("t5_load_sel_err", 32'(sel_err), 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("t5_init_out_v",   32'(out_v),   1);
      chk("t5_init_out_d_v", 32'(out_d_v), 0);
      chk("t5_init_in_r",    32'(in_r),    0);
    end
    @(negedge clk); sel = 2'd1; #1;
    chk("t5_bubble_out_v", 32'(out_v), 0);
    chk("t5_bubble_in_r",  32'(in_r),  1);
    @(negedge clk); in_v = 1'b0; #1;
    chk("t5_tok_out_v",   32'(out_v),   1);
    chk("t5_tok_out_d_v", 32'(out_d_v), 1);
    chk("t5_tok_b",       32'(out_b_v), 3'b010);

    // Maximum period 2^DELAY_W-1
    @(negedge clk); dval = 4'd15; in_v = 1'b1; sel = 2'd0; #1;
    chk("tmax_idle_out_v", 32'(out_v), 0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 15) in_v = 1'b0;
      #1;
      chk("tmax_out_v",   32'(out_v),   1);
      chk("tmax_out_d_v", 32'(out_d_v), 32'(k == 15));
    end

    // Asynchronous reset with a token held in the output register
    @(negedge clk); dval = '0; in_v = 1'b1; sel = 2'd1; #1;
    chk("t6_idle_out_v", 32'(out_v), 0);
    @(negedge clk); dout_r = '0; in_v = 1'b0; #1;
    chk("t6_stall_out_v", 32'(out_v), 0);
    chk("t6_stall_in_r",  32'(in_r),  0);
    @(negedge clk); dout_r = '1; #1;
    chk("t6_held_out_v",   32'(out_v),   1);
    chk("t6_held_b",       32'(out_b_v), 3'b010);
    chk("t6_held_out_d_v", 32'(out_d_v), 1);
    #2; rst = 1'b1; ivc = '0; #1;
    chk("t6_rst_out_v",   32'(out_v),   0);
    chk("t6_rst_b",       32'(out_b_v), 0);
    chk("t6_rst_out_d_v", 32'(out_d_v), 0);
    chk("t6_rst_in_r",    32'(in_r),    0);
    @(negedge clk); rst = 1'b0; #1;
    chk("t6_load_in_r",  32'(in_r),  0);
    chk("t6_load_out_v", 32'(out_v), 0);
    @(negedge clk); in_v = 1'b1; sel = 2'd0; #1;
    chk("t6_run_in_r",  32'(in_r),  1);
    chk("t6_run_out_v", 32'(out_v), 0);
    @(negedge clk); in_v = 1'b0; #1;
    chk("t6_tok_out_v", 32'(out_v),   1);
    chk("t6_tok_b",     32'(out_b_v), 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
